uart_rx_ctrl: RTL

- UART receive controller that sequences one receive frame: idle line monitoring, start-bit qualification, mid-bit sampling of data bits, optional parity bit, stop bit.
- Hands each received byte to the downstream consumer over a valid/ready handshake, with per-byte error flags.
- Sits between the serial pin `rxin` and the receive buffer. Supersedes ad-hoc start detection with a single sequenced FSM driven by a bit-period counter.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, parity helper and parameter limits
// common to the receiver and transmitter.
package uart_pkg;

    localparam int unsigned UART_MIN_CLKS_PER_BIT = 4;
    localparam int unsigned UART_MIN_DATA_BITS    = 5;
    localparam int unsigned UART_MAX_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    // Narrower data words are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_of(input logic [UART_MAX_DATA_BITS-1:0] data,
                                       input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous pin input; both flops reset to 1
// so an idle-high line sees no false edge when reset is released.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences one frame from the synchronized line and
// hands each byte downstream over valid/ready with parity/frame error flags.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (rxin),
        .dout (rx_s)
    );

    uart_state_e          state_d, state_q;
    logic [CW-1:0]        clk_cnt_d, clk_cnt_q;
    logic [3:0]           bit_cnt_d, bit_cnt_q;
    logic [DATA_BITS-1:0] shift_d, shift_q;
    logic                 par_pend_d, par_pend_q;
    logic                 frm_pend_d, frm_pend_q;
    logic                 deliver_d, deliver_q;
    logic [DATA_BITS-1:0] rx_data_d, rx_data_q;
    logic                 rx_valid_d, rx_valid_q;
    logic                 parity_err_d, parity_err_q;
    logic                 frame_err_d, frame_err_q;
    logic                 overrun_d, overrun_q;
    logic                 busy_d, busy_q;

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_pend_d   = par_pend_q;
        frm_pend_d   = frm_pend_q;
        deliver_d    = 1'b0;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (!rx_s) begin
                    state_d    = START;
                    par_pend_d = 1'b0;
                    frm_pend_d = 1'b0;
                end
            end
            START: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == CNT_FULL) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (clk_cnt_q == CNT_FULL) begin
                    clk_cnt_d  = '0;
                    par_pend_d = rx_s != parity_of(8'(shift_q), 1'(PARITY_ODD));
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (clk_cnt_q == CNT_FULL) begin
                    clk_cnt_d  = '0;
                    deliver_d  = 1'b1;
                    frm_pend_d = ~rx_s;
                    state_d    = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                clk_cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        // A delivery that coincides with an accept replaces the held byte in place.
        if (deliver_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                parity_err_d = par_pend_q;
                frame_err_d  = frm_pend_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_pend_q   <= 1'b0;
            frm_pend_q   <= 1'b0;
            deliver_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_pend_q   <= par_pend_d;
            frm_pend_q   <= frm_pend_d;
            deliver_q    <= deliver_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule
